// File: rtl/stack_pkg.sv
// Shared definitions for the stack ALU and its RPN token sequencer.
//   - OP_* : 3-bit stack opcodes driven on the stack's opcode input
//   - tok_kind_e  : kind of an incoming RPN token
//   - err_e       : per-expression result/error code
//   - seq_state_e : sequencer FSM states
package stack_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  typedef enum logic [1:0] {
    TOK_NUM = 2'b00,
    TOK_ADD = 2'b01,
    TOK_MUL = 2'b10,
    TOK_END = 2'b11
  } tok_kind_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_UNDERFLOW = 3'd1,
    ERR_LEFTOVER  = 3'd2,
    ERR_ARITH     = 3'd3,
    ERR_FULL      = 3'd4
  } err_e;

  typedef enum logic [2:0] {
    S_RUN,
    S_ARITH,
    S_CHECK,
    S_READ,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } seq_state_e;

  // The first error seen in an expression is the one reported.
  function automatic err_e keep_first_err(input err_e cur, input err_e cand);
    return (cur == ERR_NONE) ? cand : cur;
  endfunction

endpackage

// File: rtl/rpn_sequencer.sv
// RPN token sequencer feeding a `stack` ALU.
// Accepts postfix tokens (tok_*) over valid/ready, issues one stack opcode
// per cycle (stk_opcode/stk_data, registered), tracks operand depth locally,
// flushes the stack after every expression and returns one result or error
// code per expression over a second valid/ready handshake (res_*).
//   clk, rst_n            : clock, async active-low reset (shared with stack)
//   tok_valid/ready/kind/value : token input handshake
//   stk_opcode, stk_data  : to stack opcode/input_data
//   stk_output_data, stk_overflow : from stack (top of stack, overflow flag)
//   res_valid/ready/data/error : result handshake
//   busy                  : low only when idle in RUN with an empty stack
module rpn_sequencer
  import stack_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic [1:0]       tok_kind,
  input  logic [WIDTH-1:0] tok_value,
  output logic [2:0]       stk_opcode,
  output logic [WIDTH-1:0] stk_data,
  input  logic [WIDTH-1:0] stk_output_data,
  input  logic             stk_overflow,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [2:0]       res_error,
  output logic             busy
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] ONE       = DW'(1);
  localparam logic [DW-1:0] TWO       = DW'(2);

  seq_state_e                state_q, state_d;
  logic [DW-1:0]             depth_q, depth_d;
  err_e                      err_q, err_d;
  logic [2:0]                opcode_q, opcode_d;
  logic signed [WIDTH-1:0]   data_q, data_d;
  logic signed [WIDTH-1:0]   res_data_q, res_data_d;
  tok_kind_e                 kind;
  logic                      tok_fire;

  assign kind     = tok_kind_e'(tok_kind);
  assign tok_fire = tok_valid && tok_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      depth_q    <= '0;
      err_q      <= ERR_NONE;
      opcode_q   <= OP_NOP;
      data_q     <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      err_q      <= err_d;
      opcode_q   <= opcode_d;
      data_q     <= data_d;
      res_data_q <= res_data_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    err_d      = err_q;
    opcode_d   = OP_NOP;
    data_d     = '0;
    res_data_d = res_data_q;
    case (state_q)
      S_RUN: begin
        if (tok_fire) begin
          case (kind)
            TOK_NUM: begin
              if (depth_q < DEPTH_MAX) begin
                opcode_d = OP_PUSH;
                data_d   = tok_value;
                depth_d  = depth_q + ONE;
              end else begin
                err_d   = keep_first_err(err_q, ERR_FULL);
                state_d = S_DRAIN;
              end
            end
            TOK_ADD, TOK_MUL: begin
              if (depth_q >= TWO) begin
                opcode_d = (kind == TOK_ADD) ? OP_ADD : OP_MUL;
                depth_d  = depth_q - ONE;
                state_d  = S_ARITH;
              end else begin
                err_d   = keep_first_err(err_q, ERR_UNDERFLOW);
                state_d = S_DRAIN;
              end
            end
            TOK_END: begin
              if (depth_q == ONE) begin
                state_d = S_READ;
              end else begin
                err_d   = keep_first_err(err_q, (depth_q == '0) ? ERR_UNDERFLOW : ERR_LEFTOVER);
                state_d = S_FLUSH;
              end
            end
          endcase
        end
      end
      // The arithmetic op is on the bus this cycle; overflow is only
      // visible one cycle later, so CHECK follows unconditionally.
      S_ARITH: state_d = S_CHECK;
      S_CHECK: begin
        if (stk_overflow) begin
          err_d   = keep_first_err(err_q, ERR_ARITH);
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_READ: begin
        res_data_d = (err_q == ERR_NONE) ? stk_output_data : '0;
        state_d    = S_FLUSH;
      end
      // Swallow the rest of a failed expression up to and including END.
      S_DRAIN: begin
        if (tok_fire && (kind == TOK_END)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (depth_q != '0) begin
          opcode_d = OP_POP;
          depth_d  = depth_q - ONE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          err_d      = ERR_NONE;
          res_data_d = '0;
          state_d    = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    tok_ready = (state_q == S_RUN) || (state_q == S_DRAIN);
    res_valid = (state_q == S_DONE);
    busy      = !((state_q == S_RUN) && (depth_q == '0));
  end

  assign stk_opcode = opcode_q;
  assign stk_data   = data_q;
  assign res_data   = res_data_q;
  assign res_error  = err_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Directed bench for rpn_sequencer driving a behavioural 4-entry stack model.
module tb_rpn_sequencer;
  import stack_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       tok_valid;
  logic       tok_ready;
  logic [1:0] tok_kind;
  logic [3:0] tok_value;
  logic [2:0] stk_opcode;
  logic [3:0] stk_data;
  logic [3:0] stk_out;
  logic       ovf;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [2:0] res_error;
  logic       busy;

  int n_total = 0;
  int n_pass  = 0;

  rpn_sequencer #(.DEPTH(4), .WIDTH(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tok_valid       (tok_valid),
    .tok_ready       (tok_ready),
    .tok_kind        (tok_kind),
    .tok_value       (tok_value),
    .stk_opcode      (stk_opcode),
    .stk_data        (stk_data),
    .stk_output_data (stk_out),
    .stk_overflow    (ovf),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .res_error       (res_error),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack: executes stk_opcode at the rising edge.
  logic signed [3:0] mem [0:7];
  logic [2:0]        sp;

  function automatic int alu(input logic [2:0] op, input logic signed [3:0] a,
                             input logic signed [3:0] b);
    return (op == OP_MUL) ? int'(a) * int'(b) : int'(a) + int'(b);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp  <= '0;
      ovf <= 1'b0;
    end else begin
      case (stk_opcode)
        OP_PUSH: begin
          mem[sp] <= stk_data;
          sp      <= sp + 3'd1;
          ovf     <= 1'b0;
        end
        OP_POP: begin
          if (sp != 3'd0) sp <= sp - 3'd1;
          ovf <= 1'b0;
        end
        OP_ADD, OP_MUL: begin
          mem[sp-3'd2] <= 4'(alu(stk_opcode, mem[sp-3'd2], mem[sp-3'd1]));
          sp           <= sp - 3'd1;
          ovf          <= (alu(stk_opcode, mem[sp-3'd2], mem[sp-3'd1]) > 7) ||
                          (alu(stk_opcode, mem[sp-3'd2], mem[sp-3'd1]) < -8);
        end
        default: ;
      endcase
    end
  end

  assign stk_out = (sp != 3'd0) ? mem[sp-3'd1] : 4'd0;

  // Log every non-NOP opcode; each op is held for exactly one cycle.
  logic [2:0] op_log[$];
  always @(negedge clk) begin
    if (rst_n && stk_opcode != OP_NOP) op_log.push_back(stk_opcode);
  end

  function automatic logic [31:0] ops_since(input int base);
    logic [31:0] s = 32'd0;
    for (int i = base; i < op_log.size(); i++) s = (s << 3) | 32'(op_log[i]);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Present a token and hold it until accepted; returns at edge+1.
  task automatic send(input logic [1:0] k, input logic [3:0] v);
    int n = 0;
    tok_valid = 1'b1;
    tok_kind  = k;
    tok_value = v;
    while (!tok_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tok_accept_timeout", 32'(n < 100), 32'd1);
    @(posedge clk); #1;
    tok_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [3:0] exp_data,
                            input logic [2:0] exp_err, input int base,
                            input int exp_cnt, input logic [31:0] exp_sig,
                            input int hold);
    int n = 0;
    while (!res_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("%s_res_timeout", tag), 32'(n < 200), 32'd1);
    for (int i = 0; i < hold; i++) begin
      chk($sformatf("%s_hold_valid", tag), 32'(res_valid), 32'd1);
      chk($sformatf("%s_hold_data", tag), 32'(res_data), 32'(exp_data));
      chk($sformatf("%s_hold_tok_ready", tag), 32'(tok_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk($sformatf("%s_data", tag), 32'(res_data), 32'(exp_data));
    chk($sformatf("%s_err", tag), 32'(res_error), 32'(exp_err));
    chk($sformatf("%s_tok_ready_done", tag), 32'(tok_ready), 32'd0);
    chk($sformatf("%s_stack_empty", tag), 32'(sp), 32'd0);
    chk($sformatf("%s_op_count", tag), 32'(op_log.size() - base), 32'(exp_cnt));
    chk($sformatf("%s_op_seq", tag), ops_since(base), exp_sig);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk($sformatf("%s_valid_cleared", tag), 32'(res_valid), 32'd0);
    chk($sformatf("%s_err_cleared", tag), 32'(res_error), 32'd0);
    chk($sformatf("%s_data_cleared", tag), 32'(res_data), 32'd0);
    chk($sformatf("%s_idle", tag), {30'd0, busy, tok_ready}, 32'd1);
  endtask

  initial begin
    int base;
    rst_n     = 1'b0;
    tok_valid = 1'b0;
    tok_kind  = 2'b00;
    tok_value = 4'd0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_opcode", 32'(stk_opcode), 32'(OP_NOP));
    chk("rst_stk_data", 32'(stk_data), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_res_error", 32'(res_error), 32'd0);
    chk("rst_tok_ready", 32'(tok_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 2 3 + END -> 5
    base = op_log.size();
    send(TOK_NUM, 4'd2);
    chk("push_opcode", 32'(stk_opcode), 32'(OP_PUSH));
    chk("push_data", 32'(stk_data), 32'd2);
    chk("push_busy", 32'(busy), 32'd1);
    send(TOK_NUM, 4'd3);
    send(TOK_ADD, 4'd0);
    chk("add_opcode", 32'(stk_opcode), 32'(OP_ADD));
    chk("arith_tok_ready", 32'(tok_ready), 32'd0);
    send(TOK_END, 4'd0);
    get_result("add", 4'd5, 3'd0, base, 4, 32'o6647, 0);

    // 7 1 + 3 END -> arithmetic overflow, 3 discarded
    base = op_log.size();
    send(TOK_NUM, 4'd7);
    send(TOK_NUM, 4'd1);
    send(TOK_ADD, 4'd0);
    send(TOK_NUM, 4'd3);
    chk("drain_no_push", 32'(stk_opcode), 32'(OP_NOP));
    send(TOK_END, 4'd0);
    get_result("ovf", 4'd0, 3'd3, base, 4, 32'o6647, 0);

    // + END on empty stack -> underflow, no ops
    base = op_log.size();
    send(TOK_ADD, 4'd0);
    send(TOK_END, 4'd0);
    get_result("underflow", 4'd0, 3'd1, base, 0, 32'd0, 0);

    // 1 2 END -> leftover operands
    base = op_log.size();
    send(TOK_NUM, 4'd1);
    send(TOK_NUM, 4'd2);
    send(TOK_END, 4'd0);
    get_result("leftover", 4'd0, 3'd2, base, 4, 32'o6677, 0);

    // five NUMs into a 4-deep stack -> stack full
    base = op_log.size();
    for (int i = 0; i < 5; i++) send(TOK_NUM, 4'd1);
    send(TOK_END, 4'd0);
    get_result("full", 4'd0, 3'd4, base, 8, 32'o66667777, 0);

    // 2 3 * END with consumer stalled 5 cycles -> 6
    base = op_log.size();
    send(TOK_NUM, 4'd2);
    send(TOK_NUM, 4'd3);
    send(TOK_MUL, 4'd0);
    send(TOK_END, 4'd0);
    get_result("mul", 4'd6, 3'd0, base, 4, 32'o6657, 5);

    // async reset while the ADD is on the bus
    send(TOK_NUM, 4'd1);
    send(TOK_NUM, 4'd2);
    send(TOK_ADD, 4'd0);
    chk("pre_rst_add", 32'(stk_opcode), 32'(OP_ADD));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_opcode", 32'(stk_opcode), 32'(OP_NOP));
    chk("arst_tok_ready", 32'(tok_ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_res_error", 32'(res_error), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = op_log.size();
    send(TOK_NUM, 4'd1);
    send(TOK_END, 4'd0);
    get_result("post_rst", 4'd1, 3'd0, base, 2, 32'o67, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
